// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, two-state fetch FSM (FETCH/HOLD),
// IF/ID pipeline register and branch/jump redirect.
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   -> misaligned redirect targets raise a one-cycle misalign_err pulse
//   undefined -> misalign_err is tied low
// In both builds the redirect target has bits [1:0] cleared before loading the PC.

package instr_fetch_pkg;
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_type;
endpackage

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branchBeq,
    input  logic        branchBne,
    input  logic        jump,
    input  logic        zero,
    input  logic [15:0] br_imm,
    input  logic [25:0] j_index,
    input  logic [31:0] dec_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output opcode_type  op,
    output logic        misalign_err
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] hold_instr_q;
    logic [31:0] hold_pc4_q;
    logic        ifid_valid_q;
    logic [31:0] ifid_instr_q;
    logic [31:0] ifid_pc4_q;

    logic        redirect;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Redirect decision and target selection; jump wins over branch.
    always_comb begin
        redirect  = jump | (branchBeq & zero) | (branchBne & ~zero);
        br_target = dec_pc_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00};
        j_target  = {dec_pc_plus4[31:28], j_index, 2'b00};
        target    = jump ? j_target : br_target;
        pc_plus4  = pc_q + 32'd4;
    end

    // Fetch FSM: PC, hold buffer and IF/ID register. Redirect overrides
    // stall and imem_ready and drops any buffered or same-cycle word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            hold_instr_q <= '0;
            hold_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
        end else if (redirect) begin
            state_q      <= S_FETCH;
            pc_q         <= target & 32'hFFFF_FFFC;
            hold_instr_q <= '0;
            hold_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        pc_q <= pc_plus4;
                        if (stall) begin
                            hold_instr_q <= imem_rdata;
                            hold_pc4_q   <= pc_plus4;
                            state_q      <= S_HOLD;
                        end else begin
                            ifid_valid_q <= 1'b1;
                            ifid_instr_q <= imem_rdata;
                            ifid_pc4_q   <= pc_plus4;
                        end
                    end else if (!stall) begin
                        ifid_valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_valid_q <= 1'b1;
                        ifid_instr_q <= hold_instr_q;
                        ifid_pc4_q   <= hold_pc4_q;
                        state_q      <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    // One-cycle pulse following a redirect whose target is not word-aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect & (target[1:0] != 2'b00);
        end
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    // Request only while in FETCH; reset forces the request low immediately.
    assign imem_req       = (state_q == S_FETCH) & ~rst;
    assign imem_addr      = pc_q;
    assign if_id_valid    = ifid_valid_q;
    assign if_id_instr    = ifid_instr_q;
    assign if_id_pc_plus4 = ifid_pc4_q;
    assign op             = opcode_type'(ifid_instr_q[31:26]);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a reference model tracks PC and
// FETCH/HOLD, words accepted from memory are queued, and entries are popped
// and compared whenever decode consumes a valid IF/ID entry.

module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branchBeq;
    logic        branchBne;
    logic        jump;
    logic        zero;
    logic [15:0] br_imm;
    logic [25:0] j_index;
    logic [31:0] dec_pc_plus4;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    opcode_type  op;
    logic        misalign_err;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .branchBeq      (branchBeq),
        .branchBne      (branchBne),
        .jump           (jump),
        .zero           (zero),
        .br_imm         (br_imm),
        .j_index        (j_index),
        .dec_pc_plus4   (dec_pc_plus4),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .op             (op),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [63:0] sb_q[$];
    logic [31:0] exp_pc   = RESET_PC;
    logic        exp_hold = 1'b0;
    logic        exp_mis  = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Memory contents: a scrambled function of the address.
    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) + 32'h0000_0001;
    endfunction

    // One clock cycle: drive inputs at negedge, check outputs, advance model.
    task automatic step(input logic r, input logic s, input logic rdy,
                        input logic beq, input logic bne, input logic jmp, input logic z,
                        input logic [15:0] imm, input logic [25:0] jidx, input logic [31:0] dpc4);
        logic        taken;
        logic [31:0] tgt;
        logic [63:0] e;
        @(negedge clk);
        rst          = r;
        stall        = s;
        imem_ready   = rdy;
        branchBeq    = beq;
        branchBne    = bne;
        jump         = jmp;
        zero         = z;
        br_imm       = imm;
        j_index      = jidx;
        dec_pc_plus4 = dpc4;
        imem_rdata   = rdy ? word_of(imem_addr) : 32'hDEAD_BEEF;
        #1;
        if (!r) check("imem_addr", imem_addr, exp_pc);
        check("imem_req", 32'(imem_req), 32'(!r && !exp_hold));
        check("misalign_err", 32'(misalign_err), 32'(exp_mis));

        taken = jmp | (beq & z) | (bne & ~z);
        tgt   = jmp ? {dpc4[31:28], jidx, 2'b00}
                    : dpc4 + {{14{imm[15]}}, imm, 2'b00};

        if (r) begin
            sb_q.delete();
            exp_pc   = RESET_PC;
            exp_hold = 1'b0;
            exp_mis  = 1'b0;
            return;
        end

        if (if_id_valid && !s) begin
            if (sb_q.size() == 0) begin
                check("ifid_spurious", 32'(if_id_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("if_id_instr", if_id_instr, e[63:32]);
                check("if_id_pc_plus4", if_id_pc_plus4, e[31:0]);
                check("op", 32'(op), 32'(e[63:58]));
            end
        end

        exp_mis = 1'b0;
        if (taken) begin
            sb_q.delete();
            exp_pc   = tgt & 32'hFFFF_FFFC;
            exp_hold = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            exp_mis  = (tgt[1:0] != 2'b00);
`endif
        end else if (!exp_hold) begin
            if (rdy) begin
                sb_q.push_back({word_of(exp_pc), exp_pc + 32'd4});
                exp_pc = exp_pc + 32'd4;
                if (s) exp_hold = 1'b1;
            end
        end else if (!s) begin
            exp_hold = 1'b0;
        end
    endtask

    task automatic plain(input logic s, input logic rdy);
        step(1'b0, s, rdy, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0);
    endtask

    // Wait for the edge of the step just issued and sample just after it.
    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
        branchBeq = 1'b0; branchBne = 1'b0; jump = 1'b0; zero = 1'b1;
        br_imm = '0; j_index = '0; dec_pc_plus4 = '0;
        repeat (2) @(posedge clk);

        // Reset state
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0);
        peek();
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_instr", if_id_instr, 32'd0);
        check("rst_pc4", if_id_pc_plus4, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);

        // Streaming fetch from RESET_PC
        plain(1'b0, 1'b1);
        peek();
        check("stream_pc4_first", if_id_pc_plus4, 32'h4);
        check("stream_valid", 32'(if_id_valid), 32'd1);
        plain(1'b0, 1'b1);
        plain(1'b0, 1'b1);
        plain(1'b0, 1'b1);

        // Stall three cycles at PC=0x10
        plain(1'b1, 1'b1);
        peek();
        check("hold_req", 32'(imem_req), 32'd0);
        check("hold_ifid_pc4", if_id_pc_plus4, 32'h10);
        plain(1'b1, 1'b1);
        plain(1'b1, 1'b1);
        peek();
        check("hold_ifid_pc4_late", if_id_pc_plus4, 32'h10);
        plain(1'b0, 1'b1);
        peek();
        check("release_pc4", if_id_pc_plus4, 32'h14);
        check("release_instr", if_id_instr, word_of(32'h10));
        check("release_addr", imem_addr, 32'h14);

        // Two memory wait cycles: bubbles, PC held
        plain(1'b0, 1'b0);
        peek();
        check("bubble1_valid", 32'(if_id_valid), 32'd0);
        plain(1'b0, 1'b0);
        peek();
        check("bubble2_valid", 32'(if_id_valid), 32'd0);
        check("bubble_addr", imem_addr, 32'h14);
        plain(1'b0, 1'b1);

        // Taken bne backwards to 0x18
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h20);
        peek();
        check("bne_addr", imem_addr, 32'h18);
        check("bne_valid", 32'(if_id_valid), 32'd0);
        plain(1'b0, 1'b1);
        // Not-taken branches
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 26'h0, 32'h100);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 26'h0, 32'h100);
        // Taken beq forward
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 26'h0, 32'h200);
        peek();
        check("beq_addr", imem_addr, 32'h240);

        // Jump while stalled in HOLD drops the buffered word
        plain(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 26'h0000010, 32'h3000_0004);
        peek();
        check("jump_addr", imem_addr, 32'h3000_0040);
        check("jump_valid", 32'(if_id_valid), 32'd0);
        check("jump_req", 32'(imem_req), 32'd1);
        plain(1'b0, 1'b1);
        plain(1'b0, 1'b1);

        // Misaligned branch target
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0, 32'h0000_0102);
        peek();
        check("misalign_addr", imem_addr, 32'h100);
`ifdef FETCH_ALIGN_CHECK_EN
        check("misalign_pulse", 32'(misalign_err), 32'd1);
`else
        check("misalign_off", 32'(misalign_err), 32'd0);
`endif
        plain(1'b0, 1'b1);

        // PC wrap at top of address space
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 26'h3FF_FFFF, 32'hF000_0000);
        peek();
        check("wrap_top", imem_addr, 32'hFFFF_FFFC);
        plain(1'b0, 1'b1);
        peek();
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4", if_id_pc_plus4, 32'h0);
        plain(1'b0, 1'b1);

        // Reset mid-operation with a word buffered
        plain(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h0);
        peek();
        check("midrst_valid", 32'(if_id_valid), 32'd0);
        check("midrst_addr", imem_addr, RESET_PC);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic s, rdy, beq, bne, jmp, z, r;
            int unsigned kind;
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            beq = 1'b0; bne = 1'b0; jmp = 1'b0; z = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                kind = $urandom_range(0, 2);
                jmp  = (kind == 0);
                beq  = (kind == 1);
                bne  = (kind == 2);
                z    = 1'($urandom);
            end
            step(r, s, rdy, beq, bne, jmp, z, 16'($urandom), 26'($urandom), $urandom);
        end

        // Drain: no new fetches, decode accepting
        repeat (4) plain(1'b0, 1'b0);
        check("drain_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset (word-aligned).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port imem_req  output  1  instruction memory read request.
REQ-005 The block SHALL have port imem_addr  output  32  byte address of the request (equals PC).
REQ-006 The block SHALL have port imem_ready  input  1  imem_rdata valid this cycle for the outstanding request.
REQ-007 The block SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 The block SHALL have port stall  input  1  decode cannot accept a new IF/ID entry.
REQ-009 The block SHALL have ports branchBeq, branchBne, jump  input  1 each  decoded control from the decode stage.
REQ-010 The block SHALL have port zero  input  1  ALU/compare equality result for the decoded branch.
REQ-011 The block SHALL have ports br_imm  input  16 and j_index  input  26  immediate and jump index of the decoded instruction.
REQ-012 The block SHALL have port dec_pc_plus4  input  32  PC+4 of the instruction in decode.
REQ-013 The block SHALL have ports if_id_valid  output  1, if_id_instr  output  32, if_id_pc_plus4  output  32  IF/ID pipeline register.
REQ-014 The block SHALL have port op  output  opcode_type  if_id_instr[31:26] cast to opcode_type, feeding the control decoder.
REQ-015 The block SHALL have port misalign_err  output  1  redirect-target alignment error pulse.

Function
REQ-016 Redirect SHALL be taken when jump=1, or branchBeq=1 and zero=1, or branchBne=1 and zero=0.
REQ-017 Branch target SHALL be dec_pc_plus4 + (sign-extended br_imm << 2), modulo 2^32; jump target SHALL be {dec_pc_plus4[31:28], j_index, 2'b00}; jump has priority over branch.
REQ-018 FSM SHALL have two states: FETCH (imem_req=1, imem_addr=PC) and HOLD (imem_req=0, one fetched word buffered).
REQ-019 In FETCH with imem_ready=1 and stall=0, IF/ID SHALL load {1, imem_rdata, PC+4} next edge and PC SHALL advance by 4; state stays FETCH.
REQ-020 In FETCH with imem_ready=1 and stall=1, the word and PC+4 SHALL be captured in the hold buffer, IF/ID held unchanged, PC advanced by 4, state -> HOLD.
REQ-021 In HOLD with stall=0, IF/ID SHALL load the hold buffer, state -> FETCH; with stall=1 everything holds.
REQ-022 In FETCH with imem_ready=0, IF/ID SHALL hold when stall=1 and SHALL load if_id_valid=0 when stall=0 (bubble).
REQ-023 Redirect SHALL override stall and imem_ready in any state: PC <= target, IF/ID valid <= 0, hold buffer discarded, any same-cycle imem_rdata discarded, state -> FETCH.
REQ-024 PC wrap from 32'hFFFF_FFFC SHALL yield 32'h0000_0000.
REQ-025 Steady-state throughput SHALL be one instruction per cycle when imem_ready=1 and stall=0; fetch-to-IF/ID latency one cycle.
REQ-026 When if_id_valid=0, op SHALL still reflect if_id_instr[31:26]; consumers gate on if_id_valid.

Reset
REQ-027 While rst=1: PC <= RESET_PC, state <= FETCH, if_id_valid <= 0, if_id_instr <= 0, if_id_pc_plus4 <= 0, hold buffer cleared, misalign_err <= 0, imem_req forced 0.
REQ-028 First request (imem_addr=RESET_PC) SHALL appear in the first cycle after rst deasserts; rst mid-operation SHALL discard any outstanding fetch.

Configuration
REQ-029 With macro FETCH_ALIGN_CHECK_EN defined, a redirect with target[1:0]!=0 SHALL pulse misalign_err high for exactly the following cycle and load PC with target[1:0] forced to 2'b00.
REQ-030 Without FETCH_ALIGN_CHECK_EN, misalign_err SHALL be constant 0 and the redirect target SHALL be used with bits [1:0] forced to 2'b00.

Verification
REQ-031 Reset then imem_ready=1 constant, stall=0 -> imem_addr 0x0,0x4,0x8 on consecutive cycles, if_id_pc_plus4 0x4,0x8,0xC one cycle later.
REQ-032 stall=1 for 3 cycles while imem_ready=1 at PC=0x10 -> state HOLD, imem_req=0, IF/ID unchanged; on release IF/ID gets word@0x10, next request 0x14.
REQ-033 branchBne=1, zero=0, dec_pc_plus4=0x20, br_imm=16'hFFFE -> next imem_addr 0x18, if_id_valid=0 next cycle.
REQ-034 jump=1, j_index=26'h0000010, dec_pc_plus4=0x3000_0004 with stall=1 -> next imem_addr 0x3000_0040, hold buffer dropped.
REQ-035 imem_ready=0 for 2 cycles, stall=0 -> two bubbles (if_id_valid=0), PC unchanged.
REQ-036 FETCH_ALIGN_CHECK_EN defined, jump target forced misaligned via branch with target 0x...2 -> misalign_err=1 one cycle, imem_addr low bits 00.
